// File: rtl/dsm_ctrl_pkg.sv
// ============================================================================
// dsm_ctrl_pkg : shared state encoding and default widths for the DSM
//                decimation run-control sequencer.
// Revision     : 1.0
// ============================================================================
`default_nettype none

package dsm_ctrl_pkg;

  localparam int DEF_DW    = 40;
  localparam int DEF_CNT_W = 16;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FLUSH  = 3'd1,
    S_SETTLE = 3'd2,
    S_RUN    = 3'd3,
    S_DRAIN  = 3'd4
  } state_t;

endpackage

`default_nettype wire

// File: rtl/dsm_pair_detect.sv
// ============================================================================
// dsm_pair_detect : the filter strobes valid twice per decimated sample
//                   (average, then raw). Only the first of each pair is a primary.
// Revision        : 1.0
// ============================================================================
`default_nettype none

module dsm_pair_detect (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic valid,
  output logic primary
);

  logic phase_q;
  logic phase_d;

  always_comb begin
    phase_d = 1'b0;
    if (!clr && valid && !phase_q) phase_d = 1'b1;
  end

  assign primary = valid && !phase_q && !clr;

  always_ff @(posedge clk) begin
    if (reset) phase_q <= 1'b0;
    else       phase_q <= phase_d;
  end

endmodule

`default_nettype wire

// File: rtl/dsm_decim_ctrl.sv
// ============================================================================
// dsm_decim_ctrl : run-control sequencer for the CIC + averaging-FIR chain.
//                  Flush, settle, forward over valid/ready, burst or continuous.
// Build option   : DSM_CTRL_WATCHDOG_EN adds a sticky restart-on-stall watchdog.
// Revision       : 1.0
// ============================================================================
`default_nettype none

module dsm_decim_ctrl
  import dsm_ctrl_pkg::*;
#(
  parameter int DW        = DEF_DW,
  parameter int CNT_W     = DEF_CNT_W,
  parameter int FLUSH_CYC = 4,
  parameter int SETTLE    = 128,
  parameter int WD_CYC    = 4096
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic [CNT_W-1:0] burst_len,
  output logic             filt_rst,
  input  logic [DW-1:0]    filt_data,
  input  logic             filt_valid,
  output logic [DW-1:0]    m_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic             busy,
  output logic             settled,
  output logic             overflow,
  input  logic             clr_ovf,
  output logic [CNT_W-1:0] sample_cnt,
  output logic             wd_err
);

  localparam int FL_W = $clog2(FLUSH_CYC + 1);
  localparam int ST_W = $clog2(SETTLE + 1);

  state_t           state_q, state_d;
  logic [FL_W-1:0]  flush_cnt_q, flush_cnt_d;
  logic [ST_W-1:0]  settle_cnt_q, settle_cnt_d;
  logic [CNT_W-1:0] burst_q, burst_d;
  logic [CNT_W-1:0] sample_cnt_q, sample_cnt_d;
  logic [DW-1:0]    m_data_q, m_data_d;
  logic             m_valid_q, m_valid_d;
  logic             overflow_q, overflow_d;
  logic             filt_rst_q, filt_rst_d;
  logic             busy_q, busy_d;
  logic             settled_q, settled_d;
  logic             primary;

  dsm_pair_detect u_pair (
    .clk     (clk),
    .reset   (reset),
    .clr     (state_q == S_FLUSH),
    .valid   (filt_valid),
    .primary (primary)
  );

`ifdef DSM_CTRL_WATCHDOG_EN
  localparam int WD_W = $clog2(WD_CYC + 1);
  logic [WD_W-1:0] wd_cnt_q, wd_cnt_d;
  logic            wd_err_q, wd_err_d;
`endif

  always_comb begin
    state_d      = state_q;
    flush_cnt_d  = flush_cnt_q;
    settle_cnt_d = settle_cnt_q;
    burst_d      = burst_q;
    sample_cnt_d = sample_cnt_q;
    m_data_d     = m_data_q;
    m_valid_d    = m_valid_q;
    overflow_d   = overflow_q;
`ifdef DSM_CTRL_WATCHDOG_EN
    wd_cnt_d     = wd_cnt_q;
    wd_err_d     = wd_err_q;
`endif

    if (m_valid_q && m_ready) m_valid_d = 1'b0;
    if (clr_ovf)              overflow_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start && !stop) begin
          state_d      = S_FLUSH;
          flush_cnt_d  = '0;
          burst_d      = burst_len;
          sample_cnt_d = '0;
`ifdef DSM_CTRL_WATCHDOG_EN
          wd_err_d     = 1'b0;
`endif
        end
      end
      S_FLUSH: begin
        if (stop) begin
          state_d = S_IDLE;
        end else if (flush_cnt_q == FL_W'(FLUSH_CYC - 1)) begin
          state_d      = S_SETTLE;
          settle_cnt_d = '0;
        end else begin
          flush_cnt_d = flush_cnt_q + FL_W'(1);
        end
      end
      S_SETTLE: begin
        if (stop) begin
          state_d = S_IDLE;
        end else if (primary) begin
          // The pulse that completes the FIR window is itself discarded.
          if (settle_cnt_q == ST_W'(SETTLE - 1)) state_d = S_RUN;
          else settle_cnt_d = settle_cnt_q + ST_W'(1);
        end
      end
      S_RUN: begin
        if (stop) begin
          state_d = S_DRAIN;
        end else if (primary) begin
          if (!m_valid_q || m_ready) begin
            m_data_d  = filt_data;
            m_valid_d = 1'b1;
            if (sample_cnt_q != {CNT_W{1'b1}}) sample_cnt_d = sample_cnt_q + CNT_W'(1);
            if (burst_q != '0 && sample_cnt_d == burst_q) state_d = S_DRAIN;
          end else begin
            overflow_d = 1'b1;
          end
        end
      end
      S_DRAIN: begin
        if (!m_valid_q) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

`ifdef DSM_CTRL_WATCHDOG_EN
    // Counter only runs while parked in SETTLE/RUN; any state change restarts it.
    if ((state_q == S_SETTLE || state_q == S_RUN) && state_d == state_q) begin
      if (primary) begin
        wd_cnt_d = '0;
      end else if (wd_cnt_q == WD_W'(WD_CYC - 1)) begin
        wd_err_d     = 1'b1;
        state_d      = S_FLUSH;
        flush_cnt_d  = '0;
        sample_cnt_d = '0;
        wd_cnt_d     = '0;
      end else begin
        wd_cnt_d = wd_cnt_q + WD_W'(1);
      end
    end else begin
      wd_cnt_d = '0;
    end
`endif

    filt_rst_d = !(state_d == S_SETTLE || state_d == S_RUN);
    busy_d     = (state_d != S_IDLE);
    settled_d  = (state_d == S_RUN);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      flush_cnt_q  <= '0;
      settle_cnt_q <= '0;
      burst_q      <= '0;
      sample_cnt_q <= '0;
      m_data_q     <= '0;
      m_valid_q    <= 1'b0;
      overflow_q   <= 1'b0;
      filt_rst_q   <= 1'b1;
      busy_q       <= 1'b0;
      settled_q    <= 1'b0;
`ifdef DSM_CTRL_WATCHDOG_EN
      wd_cnt_q     <= '0;
      wd_err_q     <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      flush_cnt_q  <= flush_cnt_d;
      settle_cnt_q <= settle_cnt_d;
      burst_q      <= burst_d;
      sample_cnt_q <= sample_cnt_d;
      m_data_q     <= m_data_d;
      m_valid_q    <= m_valid_d;
      overflow_q   <= overflow_d;
      filt_rst_q   <= filt_rst_d;
      busy_q       <= busy_d;
      settled_q    <= settled_d;
`ifdef DSM_CTRL_WATCHDOG_EN
      wd_cnt_q     <= wd_cnt_d;
      wd_err_q     <= wd_err_d;
`endif
    end
  end

  assign filt_rst   = filt_rst_q;
  assign m_data     = m_data_q;
  assign m_valid    = m_valid_q;
  assign busy       = busy_q;
  assign settled    = settled_q;
  assign overflow   = overflow_q;
  assign sample_cnt = sample_cnt_q;
`ifdef DSM_CTRL_WATCHDOG_EN
  assign wd_err     = wd_err_q;
`else
  // No watchdog built in: WD_CYC is inert and the error flag stays low.
  assign wd_err     = 1'b0 && (WD_CYC > 0);
`endif

endmodule

`default_nettype wire

// File: tb/tb_dsm_decim_ctrl.sv
// ============================================================================
// tb_dsm_decim_ctrl : directed self-checking bench for dsm_decim_ctrl.
// Revision          : 1.0
// ============================================================================
`default_nettype none

module tb_dsm_decim_ctrl;

  localparam int DW    = 40;
  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             reset, start, stop, filt_valid, m_ready, clr_ovf;
  logic [CNT_W-1:0] burst_len;
  logic [DW-1:0]    filt_data;
  logic             filt_rst, m_valid, busy, settled, overflow, wd_err;
  logic [DW-1:0]    m_data;
  logic [CNT_W-1:0] sample_cnt;

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  dsm_decim_ctrl #(
    .DW(DW), .CNT_W(CNT_W), .FLUSH_CYC(4), .SETTLE(128), .WD_CYC(64)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .burst_len(burst_len),
    .filt_rst(filt_rst), .filt_data(filt_data), .filt_valid(filt_valid),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .busy(busy),
    .settled(settled), .overflow(overflow), .clr_ovf(clr_ovf),
    .sample_cnt(sample_cnt), .wd_err(wd_err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic prim(input logic [DW-1:0] d);
    filt_valid = 1'b1;
    filt_data  = d;
    tick();
  endtask

  task automatic sec(input logic [DW-1:0] d);
    filt_valid = 1'b1;
    filt_data  = ~d;
    tick();
    filt_valid = 1'b0;
  endtask

  task automatic pair(input logic [DW-1:0] d);
    prim(d);
    sec(d);
    repeat (10) tick();
  endtask

  task automatic start_run(input logic [CNT_W-1:0] len);
    burst_len = len;
    start     = 1'b1;
    tick();
    start     = 1'b0;
    repeat (4) tick();
  endtask

  task automatic settle_all();
    for (int i = 0; i < 128; i++) pair(DW'(i + 1));
  endtask

  initial begin
    #5ms;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; start = 1'b0; stop = 1'b0; filt_valid = 1'b0; m_ready = 1'b1;
    clr_ovf = 1'b0; burst_len = '0; filt_data = '0;
    tick(); tick();

    chk("rst_filt_rst",   filt_rst,   1);
    chk("rst_m_valid",    m_valid,    0);
    chk("rst_m_data",     m_data,     0);
    chk("rst_busy",       busy,       0);
    chk("rst_settled",    settled,    0);
    chk("rst_overflow",   overflow,   0);
    chk("rst_sample_cnt", sample_cnt, 0);
    chk("rst_wd_err",     wd_err,     0);
    reset = 1'b0;
    tick();

    // Continuous run: flush timing, warm-up discard, first forwarded sample.
    burst_len = '0;
    start = 1'b1; tick(); start = 1'b0;
    chk("flush_rst_first", filt_rst, 1);
    chk("flush_busy",      busy,     1);
    repeat (3) tick();
    chk("flush_rst_last",  filt_rst, 1);
    tick();
    chk("settle_rst_low",  filt_rst, 0);
    chk("settle_not_run",  settled,  0);
    settle_all();
    chk("run_settled",     settled,    1);
    chk("run_no_warmup",   m_valid,    0);
    chk("run_cnt_zero",    sample_cnt, 0);
    prim(40'h12_3456_789A);
    chk("s129_valid",      m_valid,    1);
    chk("s129_data",       m_data,     40'h12_3456_789A);
    chk("s129_cnt",        sample_cnt, 1);
    sec(40'h12_3456_789A);
    chk("sec_not_fwd",     m_valid,    0);
    chk("sec_data_hold",   m_data,     40'h12_3456_789A);
    repeat (10) tick();
    chk("run_wd_clear",    wd_err,     0);
    stop = 1'b1; tick(); stop = 1'b0;
    chk("stop_drain_busy", busy,     1);
    chk("stop_drain_rst",  filt_rst, 1);
    tick();
    chk("stop_idle",       busy,       0);
    chk("stop_cnt_hold",   sample_cnt, 1);

    // Burst of five.
    start_run(CNT_W'(5));
    settle_all();
    for (int k = 0; k < 4; k++) begin
      prim(DW'(100 + k));
      chk("burst_valid", m_valid,    1);
      chk("burst_data",  m_data,     DW'(100 + k));
      chk("burst_cnt",   sample_cnt, CNT_W'(k + 1));
      sec(DW'(100 + k));
      repeat (10) tick();
    end
    prim(DW'(104));
    chk("burst5_valid",   m_valid,    1);
    chk("burst5_cnt",     sample_cnt, 5);
    chk("burst5_drain",   settled,    0);
    chk("burst5_rst",     filt_rst,   1);
    sec(DW'(104));
    chk("burst_drained",  m_valid,    0);
    tick();
    chk("burst_idle",     busy,       0);
    chk("burst_idle_rst", filt_rst,   1);
    pair(DW'(200));
    chk("burst_no_extra", m_valid,    0);
    chk("burst_cnt_hold", sample_cnt, 5);

    // Consumer stall, overflow, clear, stop with pending sample.
    start_run('0);
    settle_all();
    m_ready = 1'b0;
    prim(40'hAA_0000_0001);
    chk("stall_first",    m_valid, 1);
    sec(40'hAA_0000_0001);
    repeat (10) tick();
    prim(40'hBB_0000_0002);
    chk("ovf_set",        overflow,   1);
    chk("ovf_data_hold",  m_data,     40'hAA_0000_0001);
    chk("ovf_cnt_hold",   sample_cnt, 1);
    sec(40'hBB_0000_0002);
    repeat (10) tick();
    pair(40'hCC_0000_0003);
    chk("ovf2_data_hold", m_data,     40'hAA_0000_0001);
    chk("ovf2_cnt_hold",  sample_cnt, 1);
    clr_ovf = 1'b1; tick(); clr_ovf = 1'b0;
    chk("ovf_cleared",    overflow,   0);
    clr_ovf = 1'b1;
    prim(40'hDD_0000_0004);
    clr_ovf = 1'b0;
    chk("ovf_set_wins",   overflow,   1);
    sec(40'hDD_0000_0004);
    repeat (10) tick();
    start = 1'b1; tick(); start = 1'b0;
    chk("start_ignored",  settled,    1);
    chk("start_ign_cnt",  sample_cnt, 1);
    stop = 1'b1; tick(); stop = 1'b0;
    chk("drain_pending",  m_valid, 1);
    repeat (3) tick();
    chk("drain_hold_v",   m_valid, 1);
    chk("drain_hold_d",   m_data,  40'hAA_0000_0001);
    chk("drain_hold_b",   busy,    1);
    m_ready = 1'b1; tick();
    chk("drain_accept",   m_valid, 0);
    chk("drain_still",    busy,    1);
    tick();
    chk("drain_idle",     busy,    0);
    clr_ovf = 1'b1; tick(); clr_ovf = 1'b0;

    // Stop during SETTLE.
    start_run('0);
    for (int i = 0; i < 10; i++) pair(DW'(i + 7));
    stop = 1'b1; tick(); stop = 1'b0;
    chk("settle_stop_idle", busy,     0);
    chk("settle_stop_rst",  filt_rst, 1);
    chk("settle_stop_nov",  m_valid,  0);

    // Reset mid-run with a pending sample.
    start_run('0);
    settle_all();
    m_ready = 1'b0;
    pair(40'hEE_0000_0005);
    prim(40'hFF_0000_0006);
    sec(40'hFF_0000_0006);
    chk("pre_rst_valid", m_valid,  1);
    chk("pre_rst_ovf",   overflow, 1);
    reset = 1'b1; tick();
    chk("mid_rst_filt_rst", filt_rst,   1);
    chk("mid_rst_m_valid",  m_valid,    0);
    chk("mid_rst_m_data",   m_data,     0);
    chk("mid_rst_busy",     busy,       0);
    chk("mid_rst_settled",  settled,    0);
    chk("mid_rst_overflow", overflow,   0);
    chk("mid_rst_cnt",      sample_cnt, 0);
    reset = 1'b0; m_ready = 1'b1;
    tick();

`ifdef DSM_CTRL_WATCHDOG_EN
    // Filter goes silent in RUN; 64 idle cycles trigger a restart.
    start_run('0);
    settle_all();
    prim(40'h11_0000_0007);
    sec(40'h11_0000_0007);
    repeat (10) tick();
    chk("wd_cnt_before", sample_cnt, 1);
    repeat (52) tick();
    chk("wd_not_yet",    wd_err,     0);
    chk("wd_still_run",  settled,    1);
    tick();
    chk("wd_fired",      wd_err,     1);
    chk("wd_flush_rst",  filt_rst,   1);
    chk("wd_flush_busy", busy,       1);
    chk("wd_cnt_clr",    sample_cnt, 0);
    repeat (2) tick();
    chk("wd_sticky",     wd_err,     1);
`else
    chk("wd_tied_low",   wd_err,     0);
`endif

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

`default_nettype wire
